// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Multiplies retire MUL_STEP multiplier bits per cycle by shift-and-add on
// magnitudes. Divides use restoring division at one quotient bit per cycle.
// A single FIX cycle then applies signs and accumulation and writes HI/LO.
//
// Handshake: an op is accepted on a rising edge where start=1, busy=0 and
// cancel=0. While busy, start is ignored (no queueing). cancel=1 while busy
// drops the op, including on the FIX cycle. done pulses for exactly one cycle
// after HI/LO have been written by a multi-cycle op.
module muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int MUL_ITERS = WIDTH / MUL_STEP;
  localparam int CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_COUNT = CW'(MUL_ITERS);
  localparam logic [CW-1:0] DIV_COUNT = CW'(WIDTH);
  localparam logic [CW-1:0] ONE       = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

  stateT state, nextState;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, prod, acc;
  logic [WIDTH-1:0]   mplier, rem, quo, dvsr, aSave;
  logic [1:0]         accMode;
  logic               negRes, negRem, divZero, isDivRun;

  logic               isMulOp, isDivOp, isSignedOp, accept;
  logic [1:0]         accModeIn;
  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH-1:0] mulSum, prodSigned, mulResult;
  logic [WIDTH:0]     divShift;
  logic [WIDTH-1:0]   divDiff, remNext, quoNext, divHi, divLo;
  logic               divGeq;

  assign busy   = (state != IDLE);
  assign accept = start && !busy && !cancel;

  // Decode the op into class, signedness and accumulate mode.
  always_comb begin
    isMulOp    = 1'b0;
    isDivOp    = 1'b0;
    isSignedOp = 1'b0;
    accModeIn  = ACC_NONE;
    case (op)
      OP_MULT:  begin isMulOp = 1'b1; isSignedOp = 1'b1; end
      OP_MULTU: begin isMulOp = 1'b1; end
      OP_DIV:   begin isDivOp = 1'b1; isSignedOp = 1'b1; end
      OP_DIVU:  begin isDivOp = 1'b1; end
      OP_MADD:  begin isMulOp = 1'b1; isSignedOp = 1'b1; accModeIn = ACC_ADD; end
      OP_MADDU: begin isMulOp = 1'b1; accModeIn = ACC_ADD; end
      OP_MSUB:  begin isMulOp = 1'b1; isSignedOp = 1'b1; accModeIn = ACC_SUB; end
      OP_MSUBU: begin isMulOp = 1'b1; accModeIn = ACC_SUB; end
      default:  begin end
    endcase
    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    absA = (isSignedOp && A[WIDTH-1]) ? -A : A;
    absB = (isSignedOp && B[WIDTH-1]) ? -B : B;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state: run the iteration count, one FIX cycle, cancel wins always.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept && isMulOp)      nextState = MUL;
        else if (accept && isDivOp) nextState = DIV;
      end
      MUL:     if (cnt == ONE) nextState = FIX;
      DIV:     if (cnt == ONE) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (cancel && busy) nextState = IDLE;
  end

  // One multiply step: add MUL_STEP shifted partial products.
  always_comb begin
    mulSum = prod;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) mulSum = mulSum + (mcand << i);
    end
  end

  // One restoring-division step on magnitudes.
  always_comb begin
    divShift = {rem, quo[WIDTH-1]};
    divGeq   = (divShift >= {1'b0, dvsr});
    // When the subtraction is kept the true difference is below dvsr,
    // so the low WIDTH bits are exact.
    divDiff  = divShift[WIDTH-1:0] - dvsr;
    remNext  = divGeq ? divDiff : divShift[WIDTH-1:0];
    quoNext  = {quo[WIDTH-2:0], divGeq};
  end

  // FIX-cycle result: apply signs, accumulation and the divide-by-zero rule.
  // Most-negative / -1 needs no special case: |q| = 2^(WIDTH-1) with positive
  // sign already reads back as A, and the remainder is 0.
  always_comb begin
    prodSigned = negRes ? -prod : prod;
    case (accMode)
      ACC_ADD: mulResult = acc + prodSigned;
      ACC_SUB: mulResult = acc - prodSigned;
      default: mulResult = prodSigned;
    endcase
    if (divZero) begin
      divHi = aSave;
      divLo = '1;
    end else begin
      divHi = negRem ? -rem : rem;
      divLo = negRes ? -quo : quo;
    end
  end

  // Datapath: latch operands on accept, iterate, write HI/LO on FIX exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      aSave    <= '0;
      accMode  <= ACC_NONE;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
      isDivRun <= 1'b0;
    end else begin
      done <= (state == FIX) && !cancel;
      if (accept) begin
        if (op == OP_MTHI) hi <= A;
        if (op == OP_MTLO) lo <= A;
        if (isMulOp) begin
          mcand    <= {{WIDTH{1'b0}}, absA};
          mplier   <= absB;
          prod     <= '0;
          acc      <= {hi, lo};
          accMode  <= accModeIn;
          negRes   <= isSignedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
          isDivRun <= 1'b0;
          cnt      <= MUL_COUNT;
        end
        if (isDivOp) begin
          rem      <= '0;
          quo      <= absA;
          dvsr     <= absB;
          aSave    <= A;
          negRes   <= isSignedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
          negRem   <= isSignedOp && A[WIDTH-1];
          divZero  <= (B == '0);
          isDivRun <= 1'b1;
          cnt      <= DIV_COUNT;
        end
      end else if (busy && cancel) begin
        cnt <= '0;
      end else begin
        case (state)
          MUL: begin
            prod   <= mulSum;
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
            cnt    <= cnt - ONE;
          end
          DIV: begin
            rem <= remNext;
            quo <= quoNext;
            cnt <= cnt - ONE;
          end
          FIX: begin
            if (isDivRun) begin
              hi <= divHi;
              lo <= divLo;
            end else begin
              {hi, lo} <= mulResult;
            end
          end
          default: begin end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed cases plus randomized ops on a 32-bit/step-2
// instance, checked by a scoreboard fed from an arithmetic reference model,
// and a small set of cases on a 16-bit/step-4 instance.
`timescale 1ns/1ps
module tb_muldiv_iter;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start, cancel, busy, done;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;

  logic        start16, cancel16, busy16, done16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;

  muldiv_iter #(.WIDTH(32), .MUL_STEP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  muldiv_iter #(.WIDTH(16), .MUL_STEP(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .A(a16), .B(b16),
    .cancel(cancel16), .hi(hi16), .lo(lo16), .busy(busy16), .done(done16)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: new {hi,lo} from plain signed/unsigned arithmetic.
  function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] hl);
    longint sp, sq, sr;
    logic [63:0] up, q64, r64;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = {32'd0, x} * {32'd0, y};
    case (o)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return hl + sp;
      OP_MADDU: return hl + up;
      OP_MSUB:  return hl - sp;
      OP_MSUBU: return hl - up;
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
        sq = longint'($signed(x)) / longint'($signed(y));
        sr = longint'($signed(x)) % longint'($signed(y));
        q64 = sq;
        r64 = sr;
        return {r64[31:0], q64[31:0]};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      OP_MTHI: return {x, hl[31:0]};
      OP_MTLO: return {hl[63:32], x};
      default: return hl;
    endcase
  endfunction

  function automatic int latency32(input logic [3:0] o);
    if (o == OP_DIV || o == OP_DIVU) return 33;
    if (o >= OP_MULT && o <= OP_MSUBU) return 17;
    return 0;
  endfunction

  // Driver: issue one op, optionally pulse an intruding start while busy,
  // measure the busy window and compare the final hi/lo.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit intrude, input string name);
    int n;
    int lat;
    lat = latency32(o);
    model_hl = ref_model(o, x, y, model_hl);
    if (lat != 0) exp_q.push_back(model_hl);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (intrude && n == 3) begin
        start = 1'b1;
        op = 4'($urandom_range(1, 10));
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " busy cycles"}, 64'(n), 64'(lat));
    check({name, " hi/lo"}, {hi, lo}, model_hl);
  endtask

  // Driver: issue an op and assert cancel during busy cycle k.
  task automatic run_cancel(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            input int k, input string name);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check({name, " busy after cancel"}, 64'(busy), 64'd0);
    check({name, " hi/lo kept"}, {hi, lo}, model_hl);
    repeat (3) begin
      @(negedge clk);
      check({name, " no done"}, 64'(done), 64'd0);
    end
  endtask

  // Driver for the 16-bit instance.
  task automatic run16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp_hl, input int lat, input string name);
    int n;
    op16 = o; a16 = x; b16 = y; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (busy16 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 64'(n), 64'(lat));
    check({name, " done"}, 64'(done16), 64'd1);
    check({name, " hi/lo"}, 64'({hi16, lo16}), 64'(exp_hl));
  endtask

  // Monitor / scoreboard: every done pulse pops one expected {hi,lo}.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected done: got hi/lo %h with no op outstanding", {hi, lo});
      end else begin
        check("scoreboard done result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] x, y;
    logic [15:0] x16, y16;
    logic [31:0] p16;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_NOP; a = '0; b = '0;
    start16 = 1'b0; cancel16 = 1'b0; op16 = OP_NOP; a16 = '0; b16 = '0;
    model_hl = '0;
    #1;
    check("reset hi/lo", {hi, lo}, 64'd0);
    check("reset busy/done", {62'd0, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "MULT");
    check("MULT value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "MULTU");
    check("MULTU value", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(OP_MTHI, 32'd0, 32'd0, 1'b0, "MTHI");
    run_op(OP_MTLO, 32'd10, 32'd0, 1'b0, "MTLO");
    run_op(OP_MADD, 32'd3, 32'd4, 1'b0, "MADD");
    check("MADD value", {hi, lo}, 64'd22);
    run_op(OP_MSUB, 32'd5, 32'd5, 1'b0, "MSUB");
    check("MSUB value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "DIV neg");
    check("DIV neg value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd7, 32'd0, 1'b0, "DIVU by zero");
    check("DIVU by zero value", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0, "DIV by zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "DIV overflow");
    check("DIV overflow value", {hi, lo}, 64'h0000_0000_8000_0000);

    run_cancel(OP_MULT, 32'd1234, 32'd5678, 5, "cancel MULT");
    run_cancel(OP_MADD, 32'd99, 32'd77, 17, "cancel MADD on FIX");
    run_cancel(OP_DIV, 32'd1000, 32'd3, 33, "cancel DIV on FIX");

    op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("start with cancel busy", 64'(busy), 64'd0);
    check("start with cancel hi/lo", {hi, lo}, model_hl);

    run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "MULTU intruded");
    run_op(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, "DIVU intruded");

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 12));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 300));
      if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      run_op(o, x, y, 1'b0, "random op");
    end

    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset hi/lo", {hi, lo}, 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_hl = '0;
    repeat (40) begin
      @(negedge clk);
      check("no done after reset", 64'(done), 64'd0);
    end
    run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, "MULTU after reset");

    run16(OP_MULT, 16'h8000, 16'h8000, 32'h4000_0000, 5, "W16 MULT");
    for (int i = 0; i < 6; i++) begin
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      p16 = {16'd0, x16} * {16'd0, y16};
      run16(OP_MULTU, x16, y16, p16, 5, "W16 MULTU");
      p16 = 32'(int'($signed(x16)) * int'($signed(y16)));
      run16(OP_MULT, x16, y16, p16, 5, "W16 MULT random");
      if (y16 != 16'd0) run16(OP_DIVU, x16, y16, {x16 % y16, x16 / y16}, 17, "W16 DIVU");
    end

    repeat (5) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit holding the architectural HI/LO pair for the EX stage. It generalises the fixed 32-bit MulDiv in four ways: configurable operand width, configurable multiply bits-per-cycle, multiply-accumulate/subtract ops, and pipeline-flush cancellation. EX drives start/op from its registered control word. It stalls the pipe on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits.
MUL_STEP, 2, multiplier bits retired per cycle; must divide WIDTH; legal values 1, 2, 4.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  issue op this cycle
op  in  4  0000 nop, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MADD, 0110 MADDU, 0111 MSUB, 1000 MSUBU, 1001 MTHI, 1010 MTLO, others nop
A  in  WIDTH  rs operand
B  in  WIDTH  rt operand
cancel  in  1  flush: abort in-flight op
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  multi-cycle op in flight
done  out  1  one-cycle pulse: hi/lo just updated by a multi-cycle op

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0. Reset mid-operation discards the op.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept: start=1 & busy=0 & cancel=0 at a rising edge. Start while busy is ignored; no queueing.
- MTHI/MTLO: hi (or lo) <= A at the accepting edge. busy stays 0, done stays 0.
- MULT/MULTU/MADD/MADDU/MSUB/MSUBU:
  - Accept latches |A|, |B| (signed ops) or A, B (unsigned ops), the result sign, and a snapshot {hi,lo} as the accumulator.
  - IDLE->MUL; busy=1 for WIDTH/MUL_STEP cycles, then FIX for 1 cycle.
  - Each MUL cycle adds MUL_STEP partial products into a 2*WIDTH product register.
  - FIX: negate the product if the sign is set. Then {hi,lo} <= p (MULT/U), {hi,lo}+p (MADD/U), or {hi,lo}-p (MSUB/U), modulo 2^(2*WIDTH).
  - At the FIX-exit edge busy falls and done pulses for 1 cycle.
  - Total busy cycles = WIDTH/MUL_STEP+1 (17 at defaults).
- DIV/DIVU:
  - Restoring division, 1 quotient bit per cycle on magnitudes. IDLE->DIV for WIDTH cycles, then FIX.
  - Busy cycles = WIDTH+1.
  - FIX: quotient sign = sign(A)^sign(B); remainder takes sign(A). lo<=quotient, hi<=remainder.
- Divide by zero (B=0, any signedness): the op still runs the full latency. Result is lo = all ones, hi = A.
- Signed overflow (A = most negative, B = -1): lo = A, hi = 0.
- cancel=1 while busy: next state IDLE, busy=0, done=0, hi/lo unchanged, accumulator snapshot discarded.
- cancel=1 together with start: nothing accepted.
- cancel=1 on the FIX cycle: the result is still not written.
- hi/lo change only at a FIX exit or an MTHI/MTLO edge. They are stable and readable at all other times, including while busy.
- EX stall = busy & (MFHI/MFLO or new muldiv op); that gating is EX's job, not this block's.

Test Plan:
- Defaults, MULT A=0xFFFFFFFF, B=0x00000002 -> busy high 17 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- MTHI 0, MTLO 10, then MADD A=3, B=4 -> hi=0, lo=22.
- Then MSUB A=5, B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, assert cancel on busy cycle 5 -> busy=0 next cycle, no done, hi/lo keep prior values.
- Start pulsed during busy -> ignored, result matches the first op only.
- Assert rst mid-DIV -> hi=lo=0 and busy=0 immediately, without a clock edge.
- Regression at WIDTH=16, MUL_STEP=4: MULT 0x8000*0x8000 -> busy 5 cycles, hi=0x4000, lo=0x0000.
